rr_arbiter_one_hot: RTL and testbench

- Round-robin arbiter with a valid/ready handshake that produces the one-hot select consumed by the downstream one-hot data mux.
- Picks one of COUNT requestors per accepted transfer and holds the grant stable while the consumer stalls.
- Rotates priority only on accept, so no requestor starves.
- Sits between the requestor valid lines and the mux/consumer of a shared resource (e.g. writeback or issue port).

---
 rtl/rr_arbiter_one_hot_if.sv | 33 +++
 rtl/rr_arbiter_one_hot.sv | 104 ++++++++++
 tb/tb_rr_arbiter_one_hot.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_one_hot_if.sv
// Request/grant bundle between requestors, the round-robin arbiter and the
// downstream consumer of the one-hot mux select.
interface rr_arbiter_one_hot_if #(
    parameter int unsigned COUNT       = 4,
    parameter int unsigned INDEX_WIDTH = $clog2(COUNT)
);
    logic [COUNT-1:0]       req_valid;
    logic [COUNT-1:0]       req_ready;
    logic                   grant_valid;
    logic [COUNT-1:0]       grant_one_hot;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   grant_ready;

    // Arbiter side.
    modport master (
        input  req_valid,
        input  grant_ready,
        output req_ready,
        output grant_valid,
        output grant_one_hot,
        output grant_index
    );

    // Requestor/consumer side.
    modport slave (
        output req_valid,
        output grant_ready,
        input  req_ready,
        input  grant_valid,
        input  grant_one_hot,
        input  grant_index
    );
endinterface

// File: rtl/rr_arbiter_one_hot.sv
// Round-robin arbiter producing a one-hot mux select with a valid/ready grant.
// A stalled grant is locked until accepted; priority rotates only on accept.
module rr_arbiter_one_hot #(
    parameter int unsigned COUNT       = 4,
    parameter int unsigned INDEX_WIDTH = $clog2(COUNT)
) (
    input logic                  CLK,
    input logic                  RST,
    rr_arbiter_one_hot_if.master bus
);
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [COUNT-1:0]       locked_q, locked_d;

    logic [COUNT-1:0]       req_valid;
    logic                   grant_ready;
    logic                   arb_found;
    logic [INDEX_WIDTH-1:0] arb_index;
    logic                   grant_valid;
    logic [COUNT-1:0]       grant_one_hot;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic [COUNT-1:0]       req_ready;
    logic                   accept;

    assign req_valid   = bus.req_valid;
    assign grant_ready = bus.grant_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            locked_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
        end
    end

    // Search starts at ptr and wraps; the first pending requestor wins.
    always_comb begin
        int unsigned idx;
        arb_found = 1'b0;
        arb_index = '0;
        idx       = 0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            idx = (32'(ptr_q) + i) % COUNT;
            if (!arb_found && req_valid[idx[INDEX_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_index = idx[INDEX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        locked_d = locked_q;
        accept   = grant_valid & grant_ready;
        if (accept) begin
            state_d  = StIdle;
            locked_d = '0;
            ptr_d    = (grant_index == INDEX_WIDTH'(COUNT - 1)) ? '0 : grant_index + 1'b1;
        end else if (grant_valid) begin
            state_d  = StLocked;
            locked_d = grant_one_hot;
        end
    end

    // Reset blanks all grant outputs so nothing is accepted in the reset cycle.
    always_comb begin
        grant_valid   = 1'b0;
        grant_one_hot = '0;
        if (!RST) begin
            unique case (state_q)
                StIdle: begin
                    grant_valid = arb_found;
                    if (arb_found) begin
                        grant_one_hot[arb_index] = 1'b1;
                    end
                end
                StLocked: begin
                    grant_valid   = 1'b1;
                    grant_one_hot = locked_q;
                end
                default: ;
            endcase
        end
        grant_index = '0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            if (grant_one_hot[i]) begin
                grant_index = INDEX_WIDTH'(i);
            end
        end
        req_ready = grant_one_hot & {COUNT{grant_ready}};
    end

    assign bus.grant_valid   = grant_valid;
    assign bus.grant_one_hot = grant_one_hot;
    assign bus.grant_index   = grant_index;
    assign bus.req_ready     = req_ready;
endmodule

// File: tb/tb_rr_arbiter_one_hot.sv
// Bench for rr_arbiter_one_hot: directed grants checked through a scoreboard,
// followed by a sticky-request soak checking one-hot, lock stability and fairness.
module tb_rr_arbiter_one_hot;
    localparam int unsigned COUNT = 4;

    logic clk;
    logic rst;
    logic soak;
    int   checks;
    int   passes;
    logic [5:0] exp_q[$];

    rr_arbiter_one_hot_if #(.COUNT(COUNT)) bus ();

    rr_arbiter_one_hot #(.COUNT(COUNT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Inputs change just after the rising edge; results are observed at the falling edge.
    task automatic drive(input logic r, input logic [3:0] req, input logic gr,
                         input logic [3:0] exp_oh, input logic [1:0] exp_idx);
        @(posedge clk);
        #1;
        rst              = r;
        bus.req_valid    = req;
        bus.grant_ready  = gr;
        if (exp_oh != 4'b0000) exp_q.push_back({exp_idx, exp_oh});
        @(negedge clk);
    endtask

    // Scoreboard monitor: every accepted grant must match the next expected one.
    always @(negedge clk) begin
        logic [5:0] e;
        if (!soak && bus.grant_valid && bus.grant_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_accept", {28'b0, bus.grant_one_hot}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("acc_one_hot", {28'b0, bus.grant_one_hot}, {28'b0, e[3:0]});
                check("acc_index", {30'b0, bus.grant_index}, {30'b0, e[5:4]});
                check("acc_req_ready", {28'b0, bus.req_ready}, {28'b0, e[3:0]});
            end
        end
    end

    initial begin
        logic [3:0] acc;
        logic [3:0] prev_oh;
        logic       prev_stall;
        int         waits[COUNT];
        int         j;
        logic [1:0] idx;

        checks = 0;
        passes = 0;
        soak   = 1'b0;
        rst    = 1'b1;
        bus.req_valid   = '0;
        bus.grant_ready = 1'b0;

        drive(1, 4'b0000, 0, 4'b0000, 0);
        drive(1, 4'b0000, 0, 4'b0000, 0);
        drive(0, 4'b0000, 0, 4'b0000, 0);
        check("rst_grant_valid", {31'b0, bus.grant_valid}, 32'h0);
        check("rst_one_hot", {28'b0, bus.grant_one_hot}, 32'h0);
        check("rst_index", {30'b0, bus.grant_index}, 32'h0);
        check("rst_req_ready", {28'b0, bus.req_ready}, 32'h0);

        // Fairness with all requesting, including the 3 -> 0 wrap.
        drive(0, 4'b1111, 1, 4'b0001, 0);
        drive(0, 4'b1111, 1, 4'b0010, 1);
        drive(0, 4'b1111, 1, 4'b0100, 2);
        drive(0, 4'b1111, 1, 4'b1000, 3);
        drive(0, 4'b1111, 1, 4'b0001, 0);
        // ptr=1; only bit 3 pending brings ptr back to 0.
        drive(0, 4'b1000, 1, 4'b1000, 3);

        // Stall for three cycles; bit 3 rises mid-stall but the lock holds.
        drive(0, 4'b0110, 0, 4'b0000, 0);
        check("stall1_one_hot", {28'b0, bus.grant_one_hot}, 32'h2);
        check("stall1_req_ready", {28'b0, bus.req_ready}, 32'h0);
        drive(0, 4'b1110, 0, 4'b0000, 0);
        check("stall2_one_hot", {28'b0, bus.grant_one_hot}, 32'h2);
        check("stall2_req_ready", {28'b0, bus.req_ready}, 32'h0);
        drive(0, 4'b1110, 0, 4'b0000, 0);
        check("stall3_one_hot", {28'b0, bus.grant_one_hot}, 32'h2);
        check("stall3_req_ready", {28'b0, bus.req_ready}, 32'h0);
        drive(0, 4'b1110, 1, 4'b0010, 1);
        drive(0, 4'b1100, 1, 4'b0100, 2);
        drive(0, 4'b1000, 1, 4'b1000, 3);

        // Skip: ptr=2 with only 0 and 1 pending wraps to 0, then 1.
        drive(0, 4'b0010, 1, 4'b0010, 1);
        drive(0, 4'b0011, 1, 4'b0001, 0);
        drive(0, 4'b0010, 1, 4'b0010, 1);

        // Sole requestor accepted back to back.
        drive(0, 4'b0100, 1, 4'b0100, 2);
        drive(0, 4'b0100, 1, 4'b0100, 2);

        // Lock on index 2, then reset mid-lock.
        drive(0, 4'b0100, 0, 4'b0000, 0);
        check("lock_one_hot", {28'b0, bus.grant_one_hot}, 32'h4);
        drive(0, 4'b0100, 0, 4'b0000, 0);
        check("lock_hold_index", {30'b0, bus.grant_index}, 32'h2);
        drive(1, 4'b1111, 1, 4'b0000, 0);
        check("rstcyc_grant_valid", {31'b0, bus.grant_valid}, 32'h0);
        check("rstcyc_req_ready", {28'b0, bus.req_ready}, 32'h0);
        drive(0, 4'b1111, 0, 4'b0000, 0);
        check("postrst_one_hot", {28'b0, bus.grant_one_hot}, 32'h1);
        check("postrst_index", {30'b0, bus.grant_index}, 32'h0);
        drive(0, 4'b1111, 1, 4'b0001, 0);
        drive(0, 4'b0000, 0, 4'b0000, 0);
        check("queue_drained", exp_q.size(), 32'h0);

        // Soak: sticky random requests, random consumer stalls.
        soak       = 1'b1;
        acc        = '0;
        prev_oh    = '0;
        prev_stall = 1'b0;
        for (int i = 0; i < COUNT; i++) waits[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid   = (bus.req_valid & ~acc) | 4'($urandom);
            bus.grant_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("soak_onehot0", {31'b0, $onehot0(bus.grant_one_hot)}, 32'h1);
            idx = 2'd0;
            for (int i = 0; i < COUNT; i++) if (bus.grant_one_hot[i]) idx = 2'(i);
            check("soak_index", {30'b0, bus.grant_index}, {30'b0, idx});
            if (prev_stall) begin
                check("soak_stable", {28'b0, bus.grant_one_hot}, {28'b0, prev_oh});
                check("soak_locked_req_held", {31'b0, |(bus.req_valid & prev_oh)}, 32'h1);
            end
            if (bus.grant_valid && bus.grant_ready) begin
                j = 0;
                for (int i = 0; i < COUNT; i++) if (bus.grant_one_hot[i]) j = i;
                check("soak_wait_bound", {31'b0, waits[j] <= COUNT - 1}, 32'h1);
                for (int i = 0; i < COUNT; i++) begin
                    if (i == j) waits[i] = 0;
                    else if (bus.req_valid[i]) waits[i] = waits[i] + 1;
                end
            end
            acc        = bus.req_ready;
            prev_stall = bus.grant_valid && !bus.grant_ready;
            prev_oh    = bus.grant_one_hot;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
